// File: rtl/mmm_sequencer_if.sv
// Request/strobe bundle between the MMM sequencer and its
// requester and datapath.
interface mmm_sequencer_if #(
  parameter int WIDTH = 8
) ();
  localparam int CW = $clog2(WIDTH);

  logic          ena;
  logic          start;
  logic          abort;
  logic          ge_mod;
  logic          busy;
  logic          ld_op;
  logic          clr_acc;
  logic          iter_en;
  logic          shift_b;
  logic          sub_en;
  logic          ld_r;
  logic [CW-1:0] iter_idx;
  logic          done;
  logic          sub_taken;

  modport master (
    output ena, start, abort, ge_mod,
    input  busy, ld_op, clr_acc, iter_en, shift_b,
    input  sub_en, ld_r, iter_idx, done, sub_taken
  );

  modport slave (
    input  ena, start, abort, ge_mod,
    output busy, ld_op, clr_acc, iter_en, shift_b,
    output sub_en, ld_r, iter_idx, done, sub_taken
  );
endinterface

// File: rtl/mmm_sequencer.sv
// Cycle controller for the bit-serial Montgomery multiplier:
// load, WIDTH iterations, optional final subtract, capture, done.
module mmm_sequencer #(
  parameter int WIDTH = 8
) (
  input  logic           clk,
  input  logic           rstb,
  mmm_sequencer_if.slave bus
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    ITER  = 3'd2,
    CHECK = 3'd3,
    SUB   = 3'd4,
    STORE = 3'd5,
    DONE  = 3'd6
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nxt;
  logic          sub_q;
  logic          sub_nxt;
  logic          go;
  logic          ld_op;
  logic          clr_acc;
  logic          iter_en;
  logic          sub_en;
  logic          ld_r;
  logic          done;

  // abort silences every strobe in the cycle it is seen
  assign go = bus.ena && !bus.abort;

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state <= IDLE;
      cnt   <= '0;
      sub_q <= 1'b0;
    end else if (bus.ena) begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      sub_q <= sub_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    sub_nxt   = sub_q;
    ld_op     = 1'b0;
    clr_acc   = 1'b0;
    iter_en   = 1'b0;
    sub_en    = 1'b0;
    ld_r      = 1'b0;
    done      = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.start && !bus.abort) begin
          state_nxt = LOAD;
        end
      end
      LOAD: begin
        ld_op     = go;
        clr_acc   = go;
        cnt_nxt   = '0;
        state_nxt = ITER;
      end
      ITER: begin
        iter_en = go;
        if (cnt == LAST) begin
          cnt_nxt   = '0;
          state_nxt = CHECK;
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      CHECK: begin
        sub_nxt   = bus.ge_mod;
        state_nxt = bus.ge_mod ? SUB : STORE;
      end
      SUB: begin
        sub_en    = go;
        state_nxt = STORE;
      end
      STORE: begin
        ld_r      = go;
        state_nxt = DONE;
      end
      DONE: begin
        done      = go;
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
    if (bus.abort && state != IDLE) begin
      state_nxt = IDLE;
      cnt_nxt   = '0;
      sub_nxt   = sub_q;
    end
  end

  assign bus.busy      = (state != IDLE);
  assign bus.ld_op     = ld_op;
  assign bus.clr_acc   = clr_acc;
  assign bus.iter_en   = iter_en;
  assign bus.shift_b   = iter_en;
  assign bus.sub_en    = sub_en;
  assign bus.ld_r      = ld_r;
  assign bus.iter_idx  = cnt;
  assign bus.done      = done;
  assign bus.sub_taken = sub_q;
endmodule
